// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   state_e  : arbiter FSM states
//   *_DEF    : default sizing of the 8-requester configuration
//   onehot() : index -> one-hot vector, bit i set for index i
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_REQ_DEF    = 8;
    localparam int IDX_W_DEF    = 3;
    localparam int MAX_HOLD_DEF = 16;

    function automatic logic [N_REQ_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
        logic [N_REQ_DEF-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   req  : request vector
//   last : index of the previous owner; the search starts at last+1
//   any  : at least one request is set
//   pick : first set request found scanning circularly from last+1
module rr_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] pick
);

    int start;
    int src;

    assign any = |req;

    // Scan the rotated vector from its highest offset down to offset 0 so
    // the lowest rotated offset (nearest to last+1) is the one that sticks;
    // un-rotating is just (start + offset) mod N_REQ.
    always_comb begin
        start = (int'(last) >= N_REQ - 1) ? 0 : int'(last) + 1;
        src   = 0;
        pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            src = (start + k) % N_REQ;
            if (req[IDX_W'(src)]) pick = IDX_W'(src);
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one downstream resource among N_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level-sensitive request vector
//   done       : owner finished (only looked at while a grant is active)
//   gnt        : registered one-hot grant
//   gnt_idx    : registered binary index of the grant (bit i -> code i)
//   gnt_valid  : a grant is active
//   timeout    : one-cycle pulse after a grant is revoked by MAX_HOLD
// A grant is released on done, on the owner dropping its request, or when it
// has been held MAX_HOLD cycles. Every release is followed by exactly one
// idle cycle before the next grant.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam bit               TO_EN     = (MAX_HOLD != 0);
    // With the timeout disabled the counter simply parks at all-ones.
    localparam logic [CNT_W-1:0] HOLD_LAST = TO_EN ? CNT_W'(MAX_HOLD - 1) : '1;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             any;
    logic [IDX_W-1:0] pick;
    logic             owner_req;
    logic             hold_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .any  (any),
        .pick (pick)
    );

    assign owner_req = req[gnt_idx_q];
    assign hold_hit  = TO_EN && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d     = GRANT;
                    gnt_d       = N_REQ'(onehot(IDX_W_DEF'(pick)));
                    gnt_idx_d   = pick;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_hit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    last_d      = gnt_idx_q;
                    // Only a pure hold-limit release reports a timeout;
                    // done and a dropped request take precedence.
                    timeout_d   = hold_hit && !done && owner_req;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
